// File: rtl/adc_pkg.sv
// Shared ADC front-end constants, used by the moving-average filter and the
// downstream voltage-to-distance stage.
package adc_pkg;

  localparam int ADC_W          = 12;
  localparam int VOLT_W         = 13;
  localparam int DEFAULT_LOG2_N = 4;

  function automatic int window_size(input int log2_n);
    return 1 << log2_n;
  endfunction

endpackage

// File: rtl/sample_ring_buffer.sv
// Circular sample store: one synchronous write port and one combinational read
// port. Contents are never cleared so the array maps onto LUTRAM.
module sample_ring_buffer #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 12
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read happens before the same-edge write lands, so rd_data is the slot being evicted.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/adc_moving_average.sv
// Boxcar average over the last 2**LOG2_N accepted ADC samples, kept as a running
// sum so each new sample costs one add and one subtract.
module adc_moving_average #(
  parameter int LOG2_N = adc_pkg::DEFAULT_LOG2_N,
  parameter int ADC_W  = adc_pkg::ADC_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_valid,
  input  logic [ADC_W-1:0]           sample,
  output logic [adc_pkg::VOLT_W-1:0] voltage,
  output logic                       voltage_valid,
  output logic                       primed
);
  import adc_pkg::*;

  localparam int SUM_W = ADC_W + LOG2_N;
  localparam logic [LOG2_N:0] FILL_MAX = {1'b1, {LOG2_N{1'b0}}};

  if (LOG2_N < 1 || LOG2_N > 8) begin : g_bad_log2_n
    $error("adc_moving_average: LOG2_N must be in 1..8");
  end

  logic [LOG2_N-1:0] wptr_reg;
  logic [LOG2_N:0]   fill_reg;
  logic [LOG2_N:0]   fill_next;
  logic [SUM_W-1:0]  sum_reg;
  logic [SUM_W-1:0]  sum_next;
  logic [ADC_W-1:0]  rd_data;
  logic [ADC_W-1:0]  oldest;
  logic [VOLT_W-1:0] voltage_reg;
  logic [VOLT_W-1:0] voltage_next;
  logic              voltage_valid_reg;
  logic              primed_reg;

  sample_ring_buffer #(
    .ADDR_W (LOG2_N),
    .DATA_W (ADC_W)
  ) u_ring (
    .clk     (clk),
    .wr_en   (sample_valid & ~reset),
    .wr_addr (wptr_reg),
    .wr_data (sample),
    .rd_addr (wptr_reg),
    .rd_data (rd_data)
  );

  assign primed_reg = (fill_reg == FILL_MAX);

  always_comb begin
    // Slots not yet written hold stale data, so they contribute zero until primed.
    oldest       = primed_reg ? rd_data : '0;
    sum_next     = sum_reg + {{LOG2_N{1'b0}}, sample} - {{LOG2_N{1'b0}}, oldest};
    voltage_next = VOLT_W'(sum_next[SUM_W-1:LOG2_N]);
    fill_next    = fill_reg;
    if (fill_reg != FILL_MAX) begin
      fill_next = fill_reg + (LOG2_N + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sum_reg           <= '0;
      wptr_reg          <= '0;
      fill_reg          <= '0;
      voltage_reg       <= '0;
      voltage_valid_reg <= 1'b0;
    end else begin
      voltage_valid_reg <= sample_valid;
      if (sample_valid) begin
        sum_reg     <= sum_next;
        wptr_reg    <= wptr_reg + LOG2_N'(1);
        fill_reg    <= fill_next;
        voltage_reg <= voltage_next;
      end
    end
  end

  assign voltage       = voltage_reg;
  assign voltage_valid = voltage_valid_reg;
  assign primed        = primed_reg;

endmodule

// File: tb/tb_adc_moving_average.sv
// Randomised self-checking bench: a 16-sample and a 2-sample filter compared
// against a history-array average model.
module tb_adc_moving_average;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_a, sv_a, vv_a, pr_a;
  logic [11:0] s_a;
  logic [12:0] v_a;
  logic        reset_b, sv_b, vv_b, pr_b;
  logic [11:0] s_b;
  logic [12:0] v_b;

  adc_moving_average #(.LOG2_N(4), .ADC_W(12)) dut_a (
    .clk           (clk),
    .reset         (reset_a),
    .sample_valid  (sv_a),
    .sample        (s_a),
    .voltage       (v_a),
    .voltage_valid (vv_a),
    .primed        (pr_a)
  );

  adc_moving_average #(.LOG2_N(1), .ADC_W(12)) dut_b (
    .clk           (clk),
    .reset         (reset_b),
    .sample_valid  (sv_b),
    .sample        (s_b),
    .voltage       (v_b),
    .voltage_valid (vv_b),
    .primed        (pr_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Model: every accepted sample since the last reset, plus the last average.
  int hist [2][1024];
  int cnt  [2];
  int last_v [2];

  task automatic check_eq(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int win_n(input int d);
    return (d == 0) ? 16 : 2;
  endfunction

  function automatic int model_avg(input int d);
    int s = 0;
    for (int k = 1; k <= win_n(d); k++) begin
      if (cnt[d] - k >= 0) s += hist[d][cnt[d] - k];
    end
    return s / win_n(d);
  endfunction

  // Drive one cycle into DUT d at a falling edge, then check its outputs one edge later.
  task automatic cycle(input int d, input bit v, input int data, input bit rst, input string tag);
    int gv, gvv, gp;
    bit exp_valid;
    reset_a = (d == 0) && rst;
    sv_a    = (d == 0) && v;
    s_a     = (d == 0) ? data[11:0] : 12'($urandom);
    reset_b = (d == 1) && rst;
    sv_b    = (d == 1) && v;
    s_b     = (d == 1) ? data[11:0] : 12'($urandom);
    @(negedge clk);
    if (rst) begin
      cnt[d]    = 0;
      last_v[d] = 0;
    end else if (v) begin
      hist[d][cnt[d]] = data & 'hFFF;
      cnt[d]++;
      last_v[d] = model_avg(d);
    end
    exp_valid = v && !rst;
    gv  = (d == 0) ? int'(v_a)  : int'(v_b);
    gvv = (d == 0) ? int'(vv_a) : int'(vv_b);
    gp  = (d == 0) ? int'(pr_a) : int'(pr_b);
    check_eq({tag, ".valid"},   gvv, int'(exp_valid));
    check_eq({tag, ".voltage"}, gv,  last_v[d]);
    check_eq({tag, ".primed"},  gp,  int'(cnt[d] >= win_n(d)));
    if (exp_valid)
      $display("dut%0d %s sample=0x%03h voltage=0x%03h primed=%0d", d, tag, data & 'hFFF, gv, gp);
  endtask

  initial begin
    int r;
    reset_a = 1'b1; reset_b = 1'b1;
    sv_a = 1'b0; sv_b = 1'b0; s_a = '0; s_b = '0;
    cnt[0] = 0; cnt[1] = 0; last_v[0] = 0; last_v[1] = 0;
    repeat (2) @(negedge clk);

    // Reset state, with sample_valid asserted to prove it is ignored.
    cycle(0, 1, 'h123, 1, "reset_a");

    for (int i = 0; i < 16; i++) cycle(0, 1, 'h800, 0, "mid");
    check_eq("mid.final_voltage", int'(v_a), 'h800);
    check_eq("mid.final_primed",  int'(pr_a), 1);

    for (int i = 0; i < 16; i++) cycle(0, 1, 'hFFF, 0, "full");
    check_eq("full.final_voltage", int'(v_a), 'hFFF);

    cycle(0, 0, 0, 1, "reset_single");
    cycle(0, 1, 'h010, 0, "single");
    check_eq("single.voltage", int'(v_a), 'h001);
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, "hold");

    // Gapped ramp covering several pointer wraps.
    cycle(0, 0, 0, 1, "reset_ramp");
    r = 0;
    for (int i = 0; i < 90; i++) begin
      if ($urandom_range(0, 2) == 0) cycle(0, 0, 0, 0, "ramp_idle");
      else begin
        cycle(0, 1, r, 0, "ramp");
        r = (r + 1) & 'hFFF;
      end
    end

    // Primed, then a one-cycle reset mid-window discards history.
    for (int i = 0; i < 20; i++) cycle(0, 1, int'($urandom_range(0, 'hFFF)), 0, "preload");
    cycle(0, 1, 'hFFF, 1, "reset_mid");
    for (int i = 0; i < 8; i++) cycle(0, 1, 'h100, 0, "refill");
    check_eq("refill.voltage", int'(v_a), 'h080);
    check_eq("refill.primed",  int'(pr_a), 0);

    cycle(0, 0, 0, 1, "reset_rand");
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) cycle(0, 0, 0, 0, "rand_idle");
      else cycle(0, 1, int'($urandom_range(0, 'hFFF)), 0, "rand");
    end

    // Two-sample window.
    cycle(1, 1, 'h555, 1, "reset_b");
    for (int i = 0; i < 10; i++) begin
      cycle(1, 1, (i % 2 == 0) ? 'h000 : 'hFFE, 0, "alt");
      if (i >= 1) check_eq("alt.voltage_7ff", int'(v_b), 'h7FF);
    end
    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) == 0) cycle(1, 0, 0, 0, "rand_b_idle");
      else cycle(1, 1, int'($urandom_range(0, 'hFFF)), 0, "rand_b");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/adc_moving_average.md
ADC_MOVING_AVERAGE -- requirements
Module: adc_moving_average

Interface
REQ-001 Parameter LOG2_N, default 4, sets the averaging window N = 2**LOG2_N samples; legal range 1..8.
REQ-002 Parameter ADC_W, default 12, sets the raw ADC sample width.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-005 sample_valid  input  1  high for one or more cycles; each high cycle delivers one new sample.
REQ-006 sample  input  ADC_W  raw unsigned ADC code; read only when sample_valid=1.
REQ-007 voltage  output  13  unsigned window average, zero-extended to 13 bits, for the downstream voltage-to-distance ROM stage.
REQ-008 voltage_valid  output  1  one-cycle pulse marking a new voltage value.
REQ-009 primed  output  1  high once N samples have been accepted since reset.

Function
REQ-010 The block SHALL keep a circular buffer of the last N accepted samples, with a LOG2_N-bit write pointer that wraps from N-1 to 0.
REQ-011 The block SHALL keep a running sum of width ADC_W+LOG2_N that never overflows.
REQ-012 On an edge with sample_valid=1, sum_next SHALL equal sum + sample - oldest; buf[wptr] SHALL take sample; wptr SHALL increment.
REQ-013 oldest SHALL be buf[wptr] when primed=1, and 0 when primed=0, so buffer contents need not be cleared.
REQ-014 A fill counter SHALL saturate at N; primed SHALL rise on the edge that accepts the N-th sample.
REQ-015 On each accepting edge, voltage SHALL be registered as sum_next >> LOG2_N (truncating) and voltage_valid SHALL be set; latency is 1 cycle.
REQ-016 voltage_valid SHALL be 0 in any cycle that does not follow an accepting edge; voltage SHALL hold its last value.
REQ-017 Before primed, voltage SHALL still update, as sum/N with zeros in the empty slots; consumers use primed to qualify it.
REQ-018 With sample_valid held high, one sample SHALL be accepted per cycle, with no back-pressure and no dropped samples.
REQ-019 At wptr wrap (N-1 to 0), the sum update SHALL be identical to any other slot.

Reset
REQ-020 While reset=1, the block SHALL set sum=0, wptr=0, fill=0, primed=0, voltage=0 and voltage_valid=0; sample_valid SHALL be ignored.
REQ-021 Reset asserted mid-window SHALL discard all history; the next N samples re-prime the block.
REQ-022 Buffer RAM contents SHALL NOT be reset, which keeps it inferable as block RAM or LUTRAM.

Structure
REQ-023 The shared package adc_pkg SHALL hold ADC_W=12, VOLT_W=13 and DEFAULT_LOG2_N=4, and SHALL be used by this block and the voltage-to-distance stage.
REQ-024 The circular buffer SHALL be a sub-module sample_ring_buffer (N x ADC_W, one write port plus one asynchronous read at wptr).
REQ-025 The running sum, fill counter and output registers SHALL remain in adc_moving_average.

Verification
REQ-026 Reset then 16 samples of 0x800, one per cycle -> voltage=0x800 with a valid pulse after each sample; primed rises with the 16th.
REQ-027 Primed at 0x800, then 16 samples of 0xFFF -> the sum reaches 0xFFF0 with no overflow, and the final voltage=0x0FFF.
REQ-028 Reset, then a single sample 0x010 -> voltage=0x001 and primed=0 one cycle later; with no further sample_valid, voltage_valid=0 and voltage holds.
REQ-029 Gapped sample_valid (random idle cycles) with an incrementing sample ramp -> voltage matches a reference model of the last 16 accepted samples every valid cycle.
REQ-030 Primed, reset for 1 cycle, then 8 samples of 0x100 -> voltage=0x080 and primed=0 after the 8th sample.
REQ-031 LOG2_N=1, alternating samples 0x000 and 0xFFE -> after priming, voltage=0x7FF on every valid cycle.
